rs_age_select: RTL and testbench

//  Parametrised successor reservation station for the Tomasulo core. Buffers up to
//  NUM_ENTRIES dispatched insns and captures operands from NUM_CDB broadcast ports,

---
 rtl/rs_age_select.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_rs_age_select.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_select.sv
// rs_age_select: age-ordered reservation station for the Tomasulo core.
//
// Holds up to NUM_ENTRIES dispatched instructions. It captures missing operands
// from NUM_CDB common-data-bus ports, and the instruction being loaded can
// capture them in the same cycle. Each cycle the oldest instruction with both
// operands ready is offered to a single functional unit, and the issued fields
// reach the FU through registers.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             drop every entry (branch mispredict)
//   load + fields     dispatch request: func, t1/t2 (source tags), dst (ROB tag),
//                     ready1/ready2, v1/v2, pc, imm
//   issue             the FU accepts an instruction this cycle
//   cdb_valid/tag/value  broadcast ports; port k sits at slice k of each bus
//   insn_ready        at least one valid entry has both operands ready
//   is_full           every entry is valid
//   free_count        number of invalid entries
//   start             registered one-cycle pulse: the *_out fields are valid
//   func_out, v1_out, v2_out, pc_out, imm_out, dst_tag  registered issued fields

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module rs_age_select #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_CDB     = 2,
  parameter int TAG_W       = `ROB_TAG_LEN,
  parameter int DATA_W      = `XLEN,
  parameter int FUNC_W      = 4,
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      load,
  input  logic [FUNC_W-1:0]         func,
  input  logic [TAG_W-1:0]          t1,
  input  logic [TAG_W-1:0]          t2,
  input  logic [TAG_W-1:0]          dst,
  input  logic                      ready1,
  input  logic                      ready2,
  input  logic [DATA_W-1:0]         v1,
  input  logic [DATA_W-1:0]         v2,
  input  logic [DATA_W-1:0]         pc,
  input  logic [DATA_W-1:0]         imm,
  input  logic                      issue,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
  output logic                      insn_ready,
  output logic                      is_full,
  output logic [CNT_W-1:0]          free_count,
  output logic                      start,
  output logic [FUNC_W-1:0]         func_out,
  output logic [DATA_W-1:0]         v1_out,
  output logic [DATA_W-1:0]         v2_out,
  output logic [DATA_W-1:0]         pc_out,
  output logic [DATA_W-1:0]         imm_out,
  output logic [TAG_W-1:0]          dst_tag
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  // Entry state
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [NUM_ENTRIES-1:0] rdy1_q, rdy1_d;
  logic [NUM_ENTRIES-1:0] rdy2_q, rdy2_d;
  logic [FUNC_W-1:0]      func_q [NUM_ENTRIES];
  logic [FUNC_W-1:0]      func_d [NUM_ENTRIES];
  logic [TAG_W-1:0]       t1_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       t1_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       t2_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       t2_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       dst_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]       dst_d  [NUM_ENTRIES];
  logic [DATA_W-1:0]      v1_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      v1_d   [NUM_ENTRIES];
  logic [DATA_W-1:0]      v2_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      v2_d   [NUM_ENTRIES];
  logic [DATA_W-1:0]      pc_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      pc_d   [NUM_ENTRIES];
  logic [DATA_W-1:0]      imm_q  [NUM_ENTRIES];
  logic [DATA_W-1:0]      imm_d  [NUM_ENTRIES];
  logic [IDX_W-1:0]       rank_q [NUM_ENTRIES];
  logic [IDX_W-1:0]       rank_d [NUM_ENTRIES];

  // Issue output registers
  logic              start_q;
  logic [FUNC_W-1:0] func_out_q;
  logic [DATA_W-1:0] v1_out_q, v2_out_q, pc_out_q, imm_out_q;
  logic [TAG_W-1:0]  dst_tag_q;

  // Combinational helpers
  logic [CNT_W-1:0]       valid_cnt;
  logic [NUM_ENTRIES-1:0] ready_vec;
  logic                   sel_found;
  logic [IDX_W-1:0]       sel_idx;
  logic [IDX_W-1:0]       sel_rank;
  logic [IDX_W-1:0]       free_idx;
  logic                   issue_fire;
  logic                   load_fire;
  logic [IDX_W-1:0]       load_rank;
  logic [DATA_W:0]        wake1 [NUM_ENTRIES];
  logic [DATA_W:0]        wake2 [NUM_ENTRIES];
  logic [DATA_W:0]        ld_wake1, ld_wake2;

  // Returns {hit, value} for a tag against all CDB ports. The loop runs from
  // the highest port down, so the lowest matching port is the one that sticks.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        vld,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] vals
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, vals[k*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Occupancy, oldest-ready selection and lowest free slot.
  always_comb begin
    valid_cnt = '0;
    ready_vec = valid_q & rdy1_q & rdy2_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    free_idx  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_cnt = valid_cnt + {{(CNT_W-1){1'b0}}, valid_q[i]};
      if (ready_vec[i] && (!sel_found || (rank_q[i] < sel_rank))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank_q[i];
      end
    end
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  assign insn_ready = |ready_vec;
  assign is_full    = &valid_q;
  assign free_count = CNT_W'(NUM_ENTRIES) - valid_cnt;

  // Flush overrides both issue and load at the same edge.
  assign issue_fire = issue && insn_ready && !flush;
  assign load_fire  = load && !is_full && !flush;
  // The new insn is youngest; if an issue removes one entry, the ranks close up.
  assign load_rank  = IDX_W'(valid_cnt - {{(CNT_W-1){1'b0}}, issue_fire});

  // CDB matches for the stored entries and for the incoming dispatch.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wake1[i] = cdb_lookup(t1_q[i], cdb_valid, cdb_tag, cdb_value);
      wake2[i] = cdb_lookup(t2_q[i], cdb_valid, cdb_tag, cdb_value);
    end
    ld_wake1 = cdb_lookup(t1, cdb_valid, cdb_tag, cdb_value);
    ld_wake2 = cdb_lookup(t2, cdb_valid, cdb_tag, cdb_value);
  end

  // Entry next state: wakeup, then issue removal, then load, with flush last.
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    func_d  = func_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    dst_d   = dst_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rank_d  = rank_q;

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && !rdy1_q[i] && wake1[i][DATA_W]) begin
        rdy1_d[i] = 1'b1;
        v1_d[i]   = wake1[i][DATA_W-1:0];
      end
      if (valid_q[i] && !rdy2_q[i] && wake2[i][DATA_W]) begin
        rdy2_d[i] = 1'b1;
        v2_d[i]   = wake2[i][DATA_W-1:0];
      end
    end

    if (issue_fire) begin
      valid_d[sel_idx] = 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid_q[i] && (rank_q[i] > sel_rank)) begin
          rank_d[i] = rank_q[i] - {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
    end

    // load_fire implies not full, so free_idx is never the slot being issued.
    if (load_fire) begin
      valid_d[free_idx] = 1'b1;
      func_d[free_idx]  = func;
      t1_d[free_idx]    = t1;
      t2_d[free_idx]    = t2;
      dst_d[free_idx]   = dst;
      pc_d[free_idx]    = pc;
      imm_d[free_idx]   = imm;
      rank_d[free_idx]  = load_rank;
      rdy1_d[free_idx]  = ready1 | ld_wake1[DATA_W];
      v1_d[free_idx]    = ready1 ? v1 : ld_wake1[DATA_W-1:0];
      rdy2_d[free_idx]  = ready2 | ld_wake2[DATA_W];
      v2_d[free_idx]    = ready2 ? v2 : ld_wake2[DATA_W-1:0];
    end

    if (flush) begin
      valid_d = '0;
    end
  end

  // Entry state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        func_q[i] <= '0;
        t1_q[i]   <= '0;
        t2_q[i]   <= '0;
        dst_q[i]  <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
        rank_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      func_q  <= func_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      dst_q   <= dst_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rank_q  <= rank_d;
    end
  end

  // Issue output registers: latch the selected entry, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b0;
      func_out_q <= '0;
      v1_out_q   <= '0;
      v2_out_q   <= '0;
      pc_out_q   <= '0;
      imm_out_q  <= '0;
      dst_tag_q  <= '0;
    end else begin
      start_q <= issue_fire;
      if (issue_fire) begin
        func_out_q <= func_q[sel_idx];
        v1_out_q   <= v1_q[sel_idx];
        v2_out_q   <= v2_q[sel_idx];
        pc_out_q   <= pc_q[sel_idx];
        imm_out_q  <= imm_q[sel_idx];
        dst_tag_q  <= dst_q[sel_idx];
      end
    end
  end

  assign start    = start_q;
  assign func_out = func_out_q;
  assign v1_out   = v1_out_q;
  assign v2_out   = v2_out_q;
  assign pc_out   = pc_out_q;
  assign imm_out  = imm_out_q;
  assign dst_tag  = dst_tag_q;

endmodule

// File: tb/tb_rs_age_select.sv
module tb_rs_age_select;
  localparam int N      = 8;
  localparam int NC     = 2;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int FUNC_W = 4;
  localparam int CNT_W  = $clog2(N + 1);
  localparam logic [FUNC_W-1:0] F_ADD = 4'd1;
  localparam logic [FUNC_W-1:0] F_SUB = 4'd2;

  logic clk = 1'b0;
  logic reset, flush, load, ready1, ready2, issue;
  logic [FUNC_W-1:0] func;
  logic [TAG_W-1:0] t1, t2, dst;
  logic [DATA_W-1:0] v1, v2, pc, imm;
  logic [NC-1:0] cdb_valid;
  logic [NC*TAG_W-1:0] cdb_tag;
  logic [NC*DATA_W-1:0] cdb_value;
  logic insn_ready, is_full, start;
  logic [CNT_W-1:0] free_count;
  logic [FUNC_W-1:0] func_out;
  logic [DATA_W-1:0] v1_out, v2_out, pc_out, imm_out;
  logic [TAG_W-1:0] dst_tag;

  int n_total = 0;
  int n_pass  = 0;

  rs_age_select #(.NUM_ENTRIES(N), .NUM_CDB(NC), .TAG_W(TAG_W), .DATA_W(DATA_W),
                  .FUNC_W(FUNC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .load(load), .func(func),
    .t1(t1), .t2(t2), .dst(dst), .ready1(ready1), .ready2(ready2),
    .v1(v1), .v2(v2), .pc(pc), .imm(imm), .issue(issue),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .insn_ready(insn_ready), .is_full(is_full), .free_count(free_count),
    .start(start), .func_out(func_out), .v1_out(v1_out), .v2_out(v2_out),
    .pc_out(pc_out), .imm_out(imm_out), .dst_tag(dst_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one edge; sample and drive 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; load = 1'b0; issue = 1'b0; func = '0;
    t1 = '0; t2 = '0; dst = '0; ready1 = 1'b0; ready2 = 1'b0;
    v1 = '0; v2 = '0; pc = '0; imm = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic set_load(input logic [FUNC_W-1:0] f, input logic [TAG_W-1:0] a,
                          input logic [TAG_W-1:0] b, input logic [TAG_W-1:0] d,
                          input logic r1, input logic r2,
                          input logic [DATA_W-1:0] x1, input logic [DATA_W-1:0] x2);
    load = 1'b1; func = f; t1 = a; t2 = b; dst = d; ready1 = r1; ready2 = r2;
    v1 = x1; v2 = x2; pc = 32'h100 + {26'd0, d}; imm = 32'h40 + {26'd0, d};
  endtask

  task automatic set_cdb(input logic [1:0] vld, input logic [TAG_W-1:0] tg0,
                         input logic [DATA_W-1:0] val0, input logic [TAG_W-1:0] tg1,
                         input logic [DATA_W-1:0] val1);
    cdb_valid = vld; cdb_tag = {tg1, tg0}; cdb_value = {val1, val0};
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_start", start, 0);
    check("rst_free", free_count, 8);
    check("rst_full", is_full, 0);
    check("rst_ready", insn_ready, 0);
    check("rst_dst", dst_tag, 0);
    check("rst_v1", v1_out, 0);

    // 1: single ADD load and issue
    set_load(F_ADD, 6'd8, 6'd9, 6'd3, 1'b1, 1'b1, 32'd1, 32'd2);
    tick(); idle();
    check("t1_ready", insn_ready, 1);
    check("t1_free", free_count, 7);
    issue = 1'b1;
    tick(); idle();
    check("t1_start", start, 1);
    check("t1_func", func_out, F_ADD);
    check("t1_v1", v1_out, 1);
    check("t1_v2", v2_out, 2);
    check("t1_dst", dst_tag, 3);
    check("t1_pc", pc_out, 32'h103);
    check("t1_imm", imm_out, 32'h43);
    check("t1_empty", free_count, 8);
    tick();
    check("t1_pulse", start, 0);
    check("t1_hold", dst_tag, 3);

    // 2: fill, drop a 9th load, drain in age order
    for (int i = 0; i < 8; i++) begin
      set_load(F_SUB, 6'd0, 6'd0, 6'(i), 1'b1, 1'b1, 32'(i), 32'd0);
      tick();
    end
    idle();
    check("t2_full", is_full, 1);
    check("t2_free0", free_count, 0);
    set_load(F_SUB, 6'd0, 6'd0, 6'd9, 1'b1, 1'b1, 32'd9, 32'd0);
    tick(); idle();
    check("t2_drop_free", free_count, 0);
    for (int i = 0; i < 8; i++) begin
      issue = 1'b1;
      tick();
      check($sformatf("t2_start%0d", i), start, 1);
      check($sformatf("t2_dst%0d", i), dst_tag, 6'(i));
    end
    idle();
    check("t2_noready", insn_ready, 0);
    check("t2_free8", free_count, 8);
    issue = 1'b1;
    tick(); idle();
    check("t2_noop_start", start, 0);
    check("t2_noop_hold", dst_tag, 7);

    // 3: wakeup of an older waiting entry
    set_load(F_ADD, 6'd5, 6'd0, 6'd1, 1'b0, 1'b1, 32'd0, 32'd0);
    tick();
    set_load(F_ADD, 6'd0, 6'd0, 6'd2, 1'b1, 1'b1, 32'd7, 32'd0);
    tick(); idle();
    issue = 1'b1;
    tick(); idle();
    check("t3_dstB", dst_tag, 2);
    set_cdb(2'b01, 6'd5, 32'h10, 6'd0, 32'd0);
    tick(); idle();
    check("t3_woken", insn_ready, 1);
    issue = 1'b1;
    tick(); idle();
    check("t3_dstA", dst_tag, 1);
    check("t3_v1", v1_out, 32'h10);

    // 3b: woken and issued at the same edge is not selectable yet
    set_load(F_ADD, 6'd6, 6'd0, 6'd4, 1'b0, 1'b1, 32'd0, 32'd0);
    tick(); idle();
    set_cdb(2'b01, 6'd6, 32'h66, 6'd0, 32'd0);
    issue = 1'b1;
    tick(); idle();
    check("t3b_nostart", start, 0);
    issue = 1'b1;
    tick(); idle();
    check("t3b_start", start, 1);
    check("t3b_dst", dst_tag, 4);
    check("t3b_v1", v1_out, 32'h66);

    // 3c: age beats index after a slot is reused
    set_load(F_ADD, 6'd0, 6'd0, 6'd30, 1'b1, 1'b1, 32'd0, 32'd0);
    tick();
    set_load(F_ADD, 6'd3, 6'd0, 6'd31, 1'b0, 1'b1, 32'd0, 32'd0);
    tick(); idle();
    issue = 1'b1;
    tick(); idle();
    check("t3c_first", dst_tag, 30);
    set_load(F_ADD, 6'd0, 6'd0, 6'd32, 1'b1, 1'b1, 32'd0, 32'd0);
    set_cdb(2'b01, 6'd3, 32'h33, 6'd0, 32'd0);
    tick(); idle();
    issue = 1'b1;
    tick();
    check("t3c_older", dst_tag, 31);
    tick(); idle();
    check("t3c_younger", dst_tag, 32);

    // 4: bypass from CDB port 1 into the insn being loaded
    set_load(F_ADD, 6'd7, 6'd0, 6'd5, 1'b0, 1'b1, 32'd0, 32'd0);
    set_cdb(2'b10, 6'd0, 32'd0, 6'd7, 32'hAA);
    tick(); idle();
    check("t4_ready", insn_ready, 1);
    issue = 1'b1;
    tick(); idle();
    check("t4_v1", v1_out, 32'hAA);
    check("t4_dst", dst_tag, 5);

    // 5: full + load + issue, then flush beating load and issue
    for (int i = 0; i < 8; i++) begin
      set_load(F_SUB, 6'd0, 6'd0, 6'(i), 1'b1, 1'b1, 32'd0, 32'd0);
      tick();
    end
    set_load(F_SUB, 6'd0, 6'd0, 6'd9, 1'b1, 1'b1, 32'd0, 32'd0);
    issue = 1'b1;
    tick(); idle();
    check("t5_start", start, 1);
    check("t5_dst", dst_tag, 0);
    check("t5_free1", free_count, 1);
    flush = 1'b1;
    tick(); idle();
    check("t5_flush_free", free_count, 8);
    for (int i = 0; i < 4; i++) begin
      set_load(F_SUB, 6'd0, 6'd0, 6'(10 + i), 1'b1, 1'b1, 32'd0, 32'd0);
      tick();
    end
    idle();
    check("t5_free4", free_count, 4);
    set_load(F_SUB, 6'd0, 6'd0, 6'd14, 1'b1, 1'b1, 32'd0, 32'd0);
    flush = 1'b1;
    issue = 1'b1;
    tick(); idle();
    check("t5_flush2_free", free_count, 8);
    check("t5_flush_start", start, 0);
    check("t5_flush_ready", insn_ready, 0);

    // 6: lowest CDB port wins; then mid-stream reset
    set_load(F_ADD, 6'd9, 6'd0, 6'd6, 1'b0, 1'b1, 32'd0, 32'd0);
    tick(); idle();
    set_cdb(2'b11, 6'd9, 32'h11, 6'd9, 32'h22);
    tick(); idle();
    issue = 1'b1;
    tick(); idle();
    check("t6_prio", v1_out, 32'h11);
    set_load(F_SUB, 6'd0, 6'd0, 6'd7, 1'b1, 1'b1, 32'd5, 32'd6);
    tick(); idle();
    issue = 1'b1;
    tick(); idle();
    check("t6_pre_start", start, 1);
    set_load(F_SUB, 6'd0, 6'd0, 6'd8, 1'b1, 1'b1, 32'd5, 32'd6);
    reset = 1'b1;
    tick(); idle();
    reset = 1'b0;
    check("t6_rst_start", start, 0);
    check("t6_rst_dst", dst_tag, 0);
    check("t6_rst_func", func_out, 0);
    check("t6_rst_v1", v1_out, 0);
    check("t6_rst_free", free_count, 8);
    check("t6_rst_ready", insn_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
